id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the 32-bit pipelined processor. It sits directly downstream of `Register_Block` and captures `Read_d1`/`Read_d2` together with the decoded instruction fields and control bits. It presents them registered to the execute stage. It also detects load-use hazards (stall plus bubble), applies branch flushes, and resolves the same-cycle write-back/read conflict on the register file.

## Interface
- `XLEN`, 32, datapath width
- `RA_W`, 5, register address width
- `CNT_W`, 16, bubble counter width
- `clk` in 1: single clock; all state updates on posedge
- `rst_n` in 1: asynchronous, active-low reset
- `id_valid` in 1: decode stage holds a valid instruction
- `id_rs1`, `id_rs2`, `id_rd` in RA_W: source and destination register numbers (same values driven to `Read_r1`/`Read_r2`)
- `id_read_d1`, `id_read_d2` in XLEN: `Read_d1`/`Read_d2` from `Register_Block`
- `id_imm` in XLEN: sign-extended immediate
- `id_alu_op` in 4: ALU operation code
- `id_alu_src`, `id_mem_read`, `id_mem_write`, `id_reg_write` in 1: control bits
- `wb_reg_write` in 1, `wb_rd` in RA_W, `wb_data` in XLEN: write-back port, same signals driven to `RegWrite`/`Write_r`/`Data`
- `flush` in 1: taken branch; kill the instruction entering EX
- `stall_o` out 1: hold PC and the IF/ID register this cycle
- `ex_valid` out 1: EX-stage instruction valid
- `ex_rs1`, `ex_rs2`, `ex_rd` out RA_W: registered register numbers
- `ex_op_a`, `ex_op_b`, `ex_imm` out XLEN: registered operands and immediate
- `ex_alu_op` out 4, `ex_alu_src`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write` out 1: registered control bits
- `bubble_cnt` out CNT_W: saturating count of inserted bubbles

## Operation
- Load-use hazard: `lu_haz` = `id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2))`.
- Bypass:
  - `byp1` = `wb_reg_write & (wb_rd != 0) & (wb_rd == id_rs1)`; `byp2` is the same with `id_rs2`.
  - With bypass, `ex_op_a` loads `wb_data` when `byp1`, otherwise `id_read_d1`.
  - `ex_op_b` follows the same rule using `byp2` and `id_read_d2`.
- `stall_o` = `~flush & (lu_haz | wb_haz)`. `wb_haz` is defined under Configuration.
- Per-edge action, in priority order:
  1. `flush`: load a bubble. `stall_o` is 0.
  2. `stall_o`: load a bubble. The ID inputs are held upstream and re-presented next cycle.
  3. Otherwise: capture all ID inputs, with `ex_valid` <= `id_valid`.
- Bubble definition:
  - `ex_valid`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write` = 0 and `ex_rd` = 0.
  - The other fields capture the current inputs; their values are don't-care.
- `id_valid` = 0 without flush or stall captures `ex_valid` = 0 with all control bits 0. This is not counted as a bubble.
- `bubble_cnt` increments on every edge that loads a bubble because of `flush` or `stall_o`. It saturates at all-ones and never wraps.
- `rd` = 0 never causes a hazard or a bypass.

## Timing
- Reset (`rst_n` low, asynchronous): every `ex_*` output = 0 and `bubble_cnt` = 0.
  - `stall_o` is combinational; with EX state reset it is driven only by `wb_haz`.
  - Reset deassertion takes effect at the next posedge.
- Reset mid-operation discards the EX instruction immediately, with no partial update.
- Latency: 1 cycle, from ID inputs at edge N to `ex_*` valid after edge N.
- `stall_o` is combinational from ID and WB inputs and EX state, and is valid in the same cycle.
- A load-use stall lasts exactly 1 cycle. After the bubble, `ex_mem_read` = 0, so `lu_haz` drops.
- Simultaneous `flush` and hazard: `flush` wins, `stall_o` = 0, one bubble, `bubble_cnt` +1.
- Register-file write and ID read on the same edge: covered by the bypass or `wb_haz`. The operand never carries a stale value.

## Configuration
- `ID_EX_WB_BYPASS_EN` defined: bypass muxes are present and `wb_haz` = 0.
- Undefined:
  - No bypass muxes.
  - `wb_haz` = `id_valid & (byp1 | byp2)`. This stalls 1 cycle; the register file then returns the written value.
  - Bubbles caused by `wb_haz` count in `bubble_cnt`.

## Test plan
- Reset: hold `rst_n` = 0 with random inputs → all `ex_*` = 0, `bubble_cnt` = 0. Release, then present `id_rs1`=5, `id_read_d1`=0x14, `id_reg_write`=1 → after 1 edge `ex_op_a`=0x14, `ex_valid`=1.
- Load-use: EX holds a load with `ex_rd`=8; ID has `id_rs2`=8 → `stall_o`=1, next `ex_valid`=0, `bubble_cnt`=1. Next cycle `stall_o`=0 and the instruction is captured.
- `rd`=0: EX load with `ex_rd`=0, ID `id_rs1`=0 → `stall_o`=0 and no bubble.
- WB conflict: `wb_reg_write`=1, `wb_rd`=9, `wb_data`=40, `id_rs1`=9, `id_read_d1`=0.
  - Macro on: `ex_op_a`=40 with no stall.
  - Macro off: 1-cycle stall, then `ex_op_a` = the register-file value 40.
- Flush plus load-use in the same cycle → `stall_o`=0, one bubble, `bubble_cnt` +1 only.
- Saturation: force 2^CNT_W+3 flushes → `bubble_cnt` = all-ones.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 32-bit pipelined processor.
// It registers the decoded instruction for the execute stage and detects
// load-use hazards, for which it stalls the front end and inserts a bubble.
// It applies branch flushes and counts every inserted bubble in a saturating
// counter. It also resolves a register-file write that lands on the same edge
// as the operand read.
// Optional feature: define ID_EX_WB_BYPASS_EN to forward write-back data
// straight into the captured operands. When undefined, such a conflict costs
// one stall cycle, after which the register file returns the written value.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   // decode stage
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic [RA_W-1:0]  id_rd,
   input  logic [XLEN-1:0]  id_read_d1,
   input  logic [XLEN-1:0]  id_read_d2,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [3:0]       id_alu_op,
   input  logic             id_alu_src,
   input  logic             id_mem_read,
   input  logic             id_mem_write,
   input  logic             id_reg_write,
   // write-back port, shared with the register file
   input  logic             wb_reg_write,
   input  logic [RA_W-1:0]  wb_rd,
   input  logic [XLEN-1:0]  wb_data,
   // taken branch
   input  logic             flush,
   // front-end hold request
   output logic             stall_o,
   // execute stage
   output logic             ex_valid,
   output logic [RA_W-1:0]  ex_rs1,
   output logic [RA_W-1:0]  ex_rs2,
   output logic [RA_W-1:0]  ex_rd,
   output logic [XLEN-1:0]  ex_op_a,
   output logic [XLEN-1:0]  ex_op_b,
   output logic [XLEN-1:0]  ex_imm,
   output logic [3:0]       ex_alu_op,
   output logic             ex_alu_src,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic             ex_reg_write,
   output logic [CNT_W-1:0] bubble_cnt
);

   logic            lu_haz;       // load in EX feeds a source of the ID instruction
   logic            byp1;         // write-back targets rs1 this edge
   logic            byp2;         // write-back targets rs2 this edge
   logic            wb_haz;       // write-back conflict that needs a stall
   logic            load_bubble;  // this edge loads a bubble into EX
   logic [XLEN-1:0] op_a_nxt;
   logic [XLEN-1:0] op_b_nxt;

   // Hazard detection, write-back conflict resolution and stall request.
   always_comb begin
      lu_haz = id_valid & ex_valid & ex_mem_read & (ex_rd != '0)
             & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
      byp1   = wb_reg_write & (wb_rd != '0) & (wb_rd == id_rs1);
      byp2   = wb_reg_write & (wb_rd != '0) & (wb_rd == id_rs2);
`ifdef ID_EX_WB_BYPASS_EN
      // Forward the value being written so the operand is never stale.
      wb_haz   = 1'b0;
      op_a_nxt = byp1 ? wb_data : id_read_d1;
      op_b_nxt = byp2 ? wb_data : id_read_d2;
`else
      // No forwarding: wait one cycle for the register file to update.
      wb_haz   = id_valid & (byp1 | byp2);
      op_a_nxt = id_read_d1;
      op_b_nxt = id_read_d2;
`endif
      // A flush kills the ID instruction anyway, so it never needs a stall.
      stall_o     = ~flush & (lu_haz | wb_haz);
      load_bubble = flush | stall_o;
   end

   // EX pipeline register: a bubble on flush or stall, otherwise capture ID.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid     <= 1'b0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_op_a      <= '0;
         ex_op_b      <= '0;
         ex_imm       <= '0;
         ex_alu_op    <= '0;
         ex_alu_src   <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_reg_write <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every register sample the
         // pre-edge values, including the EX state the hazard logic just read.
         // Datapath fields are don't-care in a bubble, so they always load.
         ex_rs1    <= id_rs1;
         ex_rs2    <= id_rs2;
         ex_op_a   <= op_a_nxt;
         ex_op_b   <= op_b_nxt;
         ex_imm    <= id_imm;
         ex_alu_op <= id_alu_op;
         if (load_bubble) begin
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            ex_alu_src   <= id_alu_src;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
         end else begin
            // An empty decode slot enters EX with every control bit clear.
            ex_valid     <= id_valid;
            ex_rd        <= id_rd;
            ex_alu_src   <= id_valid & id_alu_src;
            ex_mem_read  <= id_valid & id_mem_read;
            ex_mem_write <= id_valid & id_mem_write;
            ex_reg_write <= id_valid & id_reg_write;
         end
      end
   end

   // Saturating count of bubbles inserted by flush or stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
      end else if (load_bubble && (bubble_cnt != '1)) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage. A directed vector
// table and hand-written sequences cover the corner cases. A random phase
// then runs against an instruction-level model that holds a register file
// and an EX slot. Expectations follow the ID_EX_WB_BYPASS_EN setting.
`timescale 1ns/1ps
module tb_id_ex_stage;

   localparam int XLEN  = 32;
   localparam int RA_W  = 5;
   localparam int CNT_W = 16;
`ifdef ID_EX_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             id_valid;
   logic [RA_W-1:0]  id_rs1, id_rs2, id_rd;
   logic [XLEN-1:0]  id_read_d1, id_read_d2, id_imm;
   logic [3:0]       id_alu_op;
   logic             id_alu_src, id_mem_read, id_mem_write, id_reg_write;
   logic             wb_reg_write;
   logic [RA_W-1:0]  wb_rd;
   logic [XLEN-1:0]  wb_data;
   logic             flush;
   logic             stall_o;
   logic             ex_valid;
   logic [RA_W-1:0]  ex_rs1, ex_rs2, ex_rd;
   logic [XLEN-1:0]  ex_op_a, ex_op_b, ex_imm;
   logic [3:0]       ex_alu_op;
   logic             ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
   logic [CNT_W-1:0] bubble_cnt;

   id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_read_d1(id_read_d1), .id_read_d2(id_read_d2), .id_imm(id_imm),
      .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush), .stall_o(stall_o),
      .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
      .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
      .bubble_cnt(bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, ex_valid, 0);
      check({tag, "_rs1"}, ex_rs1, 0);
      check({tag, "_rs2"}, ex_rs2, 0);
      check({tag, "_rd"}, ex_rd, 0);
      check({tag, "_op_a"}, ex_op_a, 0);
      check({tag, "_op_b"}, ex_op_b, 0);
      check({tag, "_imm"}, ex_imm, 0);
      check({tag, "_alu_op"}, ex_alu_op, 0);
      check({tag, "_ctrl"}, {ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write}, 0);
      check({tag, "_cnt"}, bubble_cnt, 0);
   endtask

   task automatic randomize_inputs();
      id_valid     = 1'($urandom);
      id_rs1       = RA_W'($urandom);
      id_rs2       = RA_W'($urandom);
      id_rd        = RA_W'($urandom);
      id_read_d1   = $urandom;
      id_read_d2   = $urandom;
      id_imm       = $urandom;
      id_alu_op    = 4'($urandom);
      id_alu_src   = 1'($urandom);
      id_mem_read  = 1'($urandom);
      id_mem_write = 1'($urandom);
      id_reg_write = 1'($urandom);
      wb_reg_write = 1'($urandom);
      wb_rd        = RA_W'($urandom);
      wb_data      = $urandom;
      flush        = 1'($urandom);
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic mr, input logic rw);
      id_valid     = v;
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_rd        = rd;
      id_read_d1   = d1;
      id_read_d2   = d2;
      id_mem_read  = mr;
      id_reg_write = rw;
      id_mem_write = 1'b0;
      id_imm       = $urandom;
      id_alu_op    = 4'($urandom);
      id_alu_src   = 1'($urandom);
   endtask

   // Directed vectors: stimulus plus expected values after the edge.
   typedef struct {
      logic        v;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2;
      logic        mr, rw, fl;
      logic        e_stall, e_valid;
      logic [4:0]  e_rd;
      logic        e_mr, e_rw, chk_ops;
      logic [31:0] e_a, e_b;
      logic [15:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(input int v, input int rs1, input int rs2, input int rd,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input int mr, input int rw, input int fl,
                               input int e_stall, input int e_valid, input int e_rd,
                               input int e_mr, input int e_rw, input int chk_ops,
                               input logic [31:0] e_a, input logic [31:0] e_b, input int e_cnt);
      vec_t r;
      r.v = v[0];        r.rs1 = rs1[4:0];   r.rs2 = rs2[4:0];  r.rd = rd[4:0];
      r.d1 = d1;         r.d2 = d2;          r.mr = mr[0];      r.rw = rw[0];
      r.fl = fl[0];      r.e_stall = e_stall[0];                r.e_valid = e_valid[0];
      r.e_rd = e_rd[4:0];                    r.e_mr = e_mr[0];  r.e_rw = e_rw[0];
      r.chk_ops = chk_ops[0];                r.e_a = e_a;       r.e_b = e_b;
      r.e_cnt = e_cnt[15:0];
      return r;
   endfunction

   // Instruction-level model used by the random phase.
   typedef struct {
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      logic [3:0]  op;
      logic        alu_src, mr, mw, rw;
   } instr_t;

   typedef struct {
      logic        valid, bubble;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] a, b, imm;
      logic [3:0]  op;
      logic        alu_src, mr, mw, rw;
   } ex_model_t;

   // Watchdog: the bench must always terminate on its own.
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[10];
      logic [31:0] rf[8];
      instr_t      cur;
      ex_model_t   exm;
      logic        held, wbw, fl, lu, wbc1, wbc2, st;
      logic [4:0]  wrd;
      logic [31:0] wdat;
      logic [15:0] cnt_m;

      //          v rs1 rs2 rd d1     d2     mr rw fl  st val rd mr rw ops a      b      cnt
      vecs[0] = mk(1, 5, 6,  7, 32'h14, 32'h22, 0, 1, 0,  0, 1,  7, 0, 1, 1, 32'h14, 32'h22, 0);
      vecs[1] = mk(1, 1, 2,  8, 32'h01, 32'h02, 1, 1, 0,  0, 1,  8, 1, 1, 1, 32'h01, 32'h02, 0);
      vecs[2] = mk(1, 3, 8,  9, 32'h03, 32'h88, 0, 1, 0,  1, 0,  0, 0, 0, 0, 32'h00, 32'h00, 1);
      vecs[3] = mk(1, 3, 8,  9, 32'h03, 32'h88, 0, 1, 0,  0, 1,  9, 0, 1, 1, 32'h03, 32'h88, 1);
      vecs[4] = mk(1, 4, 4,  0, 32'h04, 32'h04, 1, 1, 0,  0, 1,  0, 1, 1, 1, 32'h04, 32'h04, 1);
      vecs[5] = mk(1, 0, 0,  2, 32'h00, 32'h00, 0, 1, 0,  0, 1,  2, 0, 1, 1, 32'h00, 32'h00, 1);
      vecs[6] = mk(1, 1, 1, 10, 32'h11, 32'h11, 1, 1, 0,  0, 1, 10, 1, 1, 1, 32'h11, 32'h11, 1);
      vecs[7] = mk(1,10, 3, 11, 32'hA0, 32'h30, 0, 1, 1,  0, 0,  0, 0, 0, 0, 32'h00, 32'h00, 2);
      vecs[8] = mk(1,10, 3, 11, 32'hA0, 32'h30, 0, 1, 0,  0, 1, 11, 0, 1, 1, 32'hA0, 32'h30, 2);
      vecs[9] = mk(0, 2, 2,  0, 32'h55, 32'h66, 1, 1, 0,  0, 0,  0, 0, 0, 0, 32'h00, 32'h00, 2);

      // Reset held with random inputs: EX state and counter stay cleared.
      rst_n = 1'b0;
      randomize_inputs();
      #1;
      check_reset_state("rst_async");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         randomize_inputs();
         @(posedge clk);
         #1;
      end
      check_reset_state("rst_held");

      // Release reset, then run the directed table.
      @(negedge clk);
      rst_n = 1'b1;
      wb_reg_write = 1'b0;
      wb_rd        = '0;
      wb_data      = '0;
      flush        = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         set_id(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                vecs[i].d1, vecs[i].d2, vecs[i].mr, vecs[i].rw);
         flush = vecs[i].fl;
         #1;
         check($sformatf("vec%0d_stall", i), stall_o, vecs[i].e_stall);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_valid", i), ex_valid, vecs[i].e_valid);
         check($sformatf("vec%0d_rd", i), ex_rd, vecs[i].e_rd);
         check($sformatf("vec%0d_mem_read", i), ex_mem_read, vecs[i].e_mr);
         check($sformatf("vec%0d_reg_write", i), ex_reg_write, vecs[i].e_rw);
         check($sformatf("vec%0d_mem_write", i), ex_mem_write, 0);
         check($sformatf("vec%0d_cnt", i), bubble_cnt, vecs[i].e_cnt);
         if (vecs[i].chk_ops) begin
            check($sformatf("vec%0d_op_a", i), ex_op_a, vecs[i].e_a);
            check($sformatf("vec%0d_op_b", i), ex_op_b, vecs[i].e_b);
         end
      end

      // Write-back to x9 on the same edge that ID reads x9 (stale file value 0).
      @(negedge clk);
      flush = 1'b0;
      set_id(1'b1, 5'd9, 5'd0, 5'd12, 32'd0, 32'd0, 1'b0, 1'b1);
      wb_reg_write = 1'b1;
      wb_rd        = 5'd9;
      wb_data      = 32'd40;
      #1;
`ifdef ID_EX_WB_BYPASS_EN
      check("wb_byp_stall", stall_o, 0);
      @(posedge clk);
      #1;
      check("wb_byp_valid", ex_valid, 1);
      check("wb_byp_op_a", ex_op_a, 32'd40);
      check("wb_byp_cnt", bubble_cnt, 2);
`else
      check("wb_haz_stall", stall_o, 1);
      @(posedge clk);
      #1;
      check("wb_haz_bubble", ex_valid, 0);
      check("wb_haz_cnt", bubble_cnt, 3);
      @(negedge clk);
      wb_reg_write = 1'b0;
      id_read_d1   = 32'd40;
      #1;
      check("wb_haz_release", stall_o, 0);
      @(posedge clk);
      #1;
      check("wb_haz_valid", ex_valid, 1);
      check("wb_haz_op_a", ex_op_a, 32'd40);
`endif

      // Reset mid-operation clears EX immediately, before any edge.
      @(negedge clk);
      wb_reg_write = 1'b0;
      set_id(1'b1, 5'd1, 5'd2, 5'd3, $urandom, $urandom, 1'b1, 1'b1);
      @(posedge clk);
      #2;
      check("pre_midrst_valid", ex_valid, 1);
      rst_n = 1'b0;
      #1;
      check_reset_state("midrst");
      @(negedge clk);
      rst_n = 1'b1;

      // Random phase against the instruction-level model.
      foreach (rf[i]) rf[i] = (i == 0) ? 32'd0 : $urandom;
      exm   = '{default: '0};
      cnt_m = '0;
      held  = 1'b0;
      cur   = '{default: '0};
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         if (!held) begin
            cur.valid   = ($urandom_range(0, 7) != 0);
            cur.rs1     = 5'($urandom_range(0, 7));
            cur.rs2     = 5'($urandom_range(0, 7));
            cur.rd      = 5'($urandom_range(0, 7));
            cur.imm     = $urandom;
            cur.op      = 4'($urandom);
            cur.alu_src = 1'($urandom);
            cur.mr      = ($urandom_range(0, 2) == 0);
            cur.mw      = 1'($urandom);
            cur.rw      = 1'($urandom);
         end
         wbw  = 1'($urandom);
         wrd  = 5'($urandom_range(0, 7));
         wdat = $urandom;
         fl   = ($urandom_range(0, 9) == 0);

         id_valid     = cur.valid;
         id_rs1       = cur.rs1;
         id_rs2       = cur.rs2;
         id_rd        = cur.rd;
         id_read_d1   = rf[cur.rs1[2:0]];
         id_read_d2   = rf[cur.rs2[2:0]];
         id_imm       = cur.imm;
         id_alu_op    = cur.op;
         id_alu_src   = cur.alu_src;
         id_mem_read  = cur.mr;
         id_mem_write = cur.mw;
         id_reg_write = cur.rw;
         wb_reg_write = wbw;
         wb_rd        = wrd;
         wb_data      = wdat;
         flush        = fl;

         lu   = cur.valid && exm.valid && exm.mr && (exm.rd != 0)
                && ((exm.rd == cur.rs1) || (exm.rd == cur.rs2));
         wbc1 = wbw && (wrd != 0) && (wrd == cur.rs1);
         wbc2 = wbw && (wrd != 0) && (wrd == cur.rs2);
         st   = !fl && (lu || (!BYP && cur.valid && (wbc1 || wbc2)));
         #1;
         check("rnd_stall", stall_o, st);

         @(posedge clk);
         if (fl || st) begin
            exm.valid  = 1'b0;
            exm.bubble = 1'b1;
            exm.rd     = 5'd0;
            exm.mr     = 1'b0;
            exm.mw     = 1'b0;
            exm.rw     = 1'b0;
            if (cnt_m != 16'hFFFF) cnt_m++;
         end else begin
            exm.valid   = cur.valid;
            exm.bubble  = 1'b0;
            exm.rs1     = cur.rs1;
            exm.rs2     = cur.rs2;
            exm.rd      = cur.rd;
            exm.a       = wbc1 ? wdat : rf[cur.rs1[2:0]];
            exm.b       = wbc2 ? wdat : rf[cur.rs2[2:0]];
            exm.imm     = cur.imm;
            exm.op      = cur.op;
            exm.alu_src = cur.alu_src;
            exm.mr      = cur.valid && cur.mr;
            exm.mw      = cur.valid && cur.mw;
            exm.rw      = cur.valid && cur.rw;
         end
         if (wbw && (wrd != 0)) rf[wrd[2:0]] = wdat;
         held = st;
         #1;
         check("rnd_valid", ex_valid, exm.valid);
         check("rnd_ctrl", {ex_mem_read, ex_mem_write, ex_reg_write}, {exm.mr, exm.mw, exm.rw});
         check("rnd_cnt", bubble_cnt, cnt_m);
         if (exm.valid || exm.bubble) check("rnd_rd", ex_rd, exm.rd);
         if (exm.valid) begin
            check("rnd_op_a", ex_op_a, exm.a);
            check("rnd_op_b", ex_op_b, exm.b);
            check("rnd_imm", ex_imm, exm.imm);
            check("rnd_alu", {ex_alu_op, ex_alu_src}, {exm.op, exm.alu_src});
            check("rnd_rs", {ex_rs1, ex_rs2}, {exm.rs1, exm.rs2});
         end
      end

      // Saturation: 2^CNT_W + 3 consecutive flushes from a cleared counter.
      @(negedge clk);
      rst_n = 1'b0;
      wb_reg_write = 1'b0;
      #1;
      check("sat_start", bubble_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      flush = 1'b1;
      for (int i = 0; i < 65534; i++) @(posedge clk);
      #1;
      check("sat_fffe", bubble_cnt, 16'hFFFE);
      @(posedge clk);
      #1;
      check("sat_ffff", bubble_cnt, 16'hFFFF);
      for (int i = 0; i < 4; i++) @(posedge clk);
      #1;
      check("sat_hold", bubble_cnt, 16'hFFFF);
      check("sat_valid", ex_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
